// File: rtl/i2s_pkg.sv
// Shared I2S constants and FSM state type for the transmitter and receiver.
// Frame layout: SLOTS bck periods per stereo frame, SAMPLE_W bits per channel.
package i2s_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned SLOTS    = 32;
  localparam int unsigned SLOT_W   = $clog2(SLOTS);
  localparam int unsigned FRAME_W  = 2 * SAMPLE_W;

  typedef enum logic {
    StIdle,
    StRun
  } i2s_state_e;

  // Word select is low for the first half of the frame (left), high for the second (right).
  function automatic logic slot_lrck(input logic [SLOT_W-1:0] slot);
    return slot >= SLOT_W'(SLOTS / 2);
  endfunction

endpackage

// File: rtl/i2s_xmtr.sv
// I2S transmitter: one-entry holding register feeding a 32-bit shift register,
// bck = clk/2, left/right words sent MSB first with the standard one-bit delay.
module i2s_xmtr
  import i2s_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_left,
  input  logic [SAMPLE_W-1:0] in_right,
  output logic                in_ready,
  output logic                bck,
  output logic                lrck,
  output logic                data,
  output logic                underrun
);

  i2s_state_e state_q, state_d;

  logic               bck_q, bck_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic               lrck_q, lrck_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [FRAME_W-1:0] hold_q, hold_d;
  logic               in_ready_q, in_ready_d;
  logic               underrun_q, underrun_d;

  logic [SLOT_W-1:0]  slot_next;
  logic               fall;
  logic               frame_edge;
  logic               load;
  logic               shift;
  logic               xfer;

  // Frame-boundary decode shared by the FSM and the datapath.
  always_comb begin
    slot_next  = slot_q + SLOT_W'(1);
    fall       = (state_q == StRun) && bck_q;
    frame_edge = fall && (slot_next == SLOT_W'(1));
    load       = frame_edge && enable;
    shift      = fall && !frame_edge;
    xfer       = in_valid && in_ready_q;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: enable only matters in IDLE and at the slot-1 boundary.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (enable) state_d = StRun;
      StRun:  if (frame_edge && !enable) state_d = StIdle;
    endcase
  end

  // Datapath next state. Anything other than staying in RUN parks the serial side at zero.
  always_comb begin
    bck_d      = 1'b0;
    slot_d     = '0;
    lrck_d     = 1'b0;
    shreg_d    = '0;
    hold_d     = hold_q;
    in_ready_d = in_ready_q;
    underrun_d = 1'b0;

    if ((state_q == StRun) && (state_d == StRun)) begin
      bck_d   = ~bck_q;
      slot_d  = slot_q;
      lrck_d  = lrck_q;
      shreg_d = shreg_q;
      if (fall) begin
        slot_d = slot_next;
        lrck_d = slot_lrck(slot_next);
      end
      if (load) begin
        // in_ready high means the holding register is empty.
        shreg_d    = in_ready_q ? '0 : hold_q;
        underrun_d = in_ready_q;
      end else if (shift) begin
        shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
      end
    end

    if (load && !in_ready_q) begin
      in_ready_d = 1'b1;
    end
    // A transfer needs in_ready high, so it can never collide with a load of held data.
    if (xfer) begin
      hold_d     = {in_left, in_right};
      in_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bck_q      <= 1'b0;
      slot_q     <= '0;
      lrck_q     <= 1'b0;
      shreg_q    <= '0;
      hold_q     <= '0;
      in_ready_q <= 1'b1;
      underrun_q <= 1'b0;
    end else begin
      bck_q      <= bck_d;
      slot_q     <= slot_d;
      lrck_q     <= lrck_d;
      shreg_q    <= shreg_d;
      hold_q     <= hold_d;
      in_ready_q <= in_ready_d;
      underrun_q <= underrun_d;
    end
  end

  // Outputs are all straight from registers.
  always_comb begin
    bck      = bck_q;
    lrck     = lrck_q;
    data     = shreg_q[FRAME_W-1];
    in_ready = in_ready_q;
    underrun = underrun_q;
  end

endmodule

// File: doc/i2s_xmtr.md
I2S_XMTR -- requirements
Module: i2s_xmtr

Interface
REQ-001 The block SHALL have no parameters; constants SAMPLE_W = 16 (bits per channel) and SLOTS = 32 (bck periods per stereo frame) SHALL come from i2s_pkg.
REQ-002 The block SHALL have one clock, and its reset SHALL be synchronous and active-high.
REQ-003 clk  in  1  system clock, 24 MHz; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 enable  in  1  start/continue transmission; sampled at frame boundaries only.
REQ-006 in_valid  in  1  stereo sample offered.
REQ-007 in_left  in  16  left sample, two's complement.
REQ-008 in_right  in  16  right sample, two's complement.
REQ-009 in_ready  out  1  holding register empty; transfer when in_valid && in_ready.
REQ-010 bck  out  1  I2S bit clock, clk/2 (12 MHz) while running.
REQ-011 lrck  out  1  word select; 0 = left, 1 = right.
REQ-012 data  out  1  serial data, MSB first; changes only with a bck falling edge.
REQ-013 underrun  out  1  one-clk pulse when a frame loads with no sample available.

Function
REQ-014 The FSM SHALL have states IDLE and RUN; in IDLE, bck, lrck and data SHALL be held at 0.
REQ-015 IDLE -> RUN on the clk after enable = 1; the first RUN cycle SHALL have bck = 0, slot = 0, lrck = 0, data = 0.
REQ-016 In RUN, bck SHALL toggle every clk; each bck 1->0 transition ("fall") SHALL advance the 5-bit slot counter mod 32.
REQ-017 lrck SHALL be 0 for slots 0-15 and 1 for slots 16-31, updated at the same fall.
REQ-018 At the fall entering slot 1, the block SHALL load a 32-bit shift register with {left,right} from the holding register; data SHALL always equal the shift register MSB.
REQ-019 At the falls entering slots 2-31 and 0, the shift register SHALL shift left by one, giving left MSB in slot 1, right MSB in slot 17, and right LSB in slot 0 of the next frame (standard I2S one-bit delay).
REQ-020 If the holding register is empty at the slot-1 load, the block SHALL load 32'h0 and assert underrun for exactly that clk.
REQ-021 At the fall that would enter slot 1, if enable = 0, the FSM SHALL go to IDLE, perform no load, and drive bck, lrck and data to 0 from the next clk.
REQ-022 The holding register SHALL be one entry; in_ready SHALL be registered and drop on the clk after a transfer.
REQ-023 The holding register SHALL be emptied by the slot-1 load, with in_ready rising on the following clk; a transfer and a load SHALL never coincide.
REQ-024 in_valid while in_ready = 0 SHALL be ignored, and in_left/in_right SHALL be don't-care.
REQ-025 Holding-register contents SHALL persist across IDLE and be sent on the first frame after re-enable.

Reset
REQ-026 On reset, outputs SHALL be: bck = 0, lrck = 0, data = 0, in_ready = 1, underrun = 0; state = IDLE, slot = 0, shift register = 0, holding register empty.
REQ-027 Reset mid-frame SHALL abort the frame immediately on the next clk, with no partial completion and the held sample discarded.

Structure
REQ-028 i2s_pkg SHALL hold SAMPLE_W, SLOTS, and the state enum (IDLE, RUN), shared with i2s_rcvr.
REQ-029 The block SHALL be a single module with no sub-module; bck generation, slot counter, shift register and holding register are all inline.

Verification
REQ-030 The bench SHALL cover: reset held, then enable = 1 -> first bck rise 2 clk later; lrck period = 64 clk; bck period = 2 clk.
REQ-031 The bench SHALL cover: one transfer of left = 16'hA5C3, right = 16'h0FF0 before slot 1 -> slots 1-16 carry A5C3 MSB-first, slots 17-31 and the next slot 0 carry 0FF0, and a loopback i2s_rcvr yields the same words.
REQ-032 The bench SHALL cover: no transfer -> frame of all zeros and exactly one 1-clk underrun pulse per frame.
REQ-033 The bench SHALL cover: in_valid held high with incrementing data -> in_ready low after each transfer, high 1 clk after each slot-1 load, and one sample per 64 clk with none lost.
REQ-034 The bench SHALL cover: enable dropped at slot 10 -> current frame completes through slot 0 of the next frame, then bck, lrck and data are 0 and stay 0.
REQ-035 The bench SHALL cover: reset asserted at slot 20 -> all outputs match reset values on the next clk and in_ready = 1.
